// File: rtl/plugboard_programmer.sv
// Sequential writer for the plugboard LUT: validates plug/unplug/clear commands
// against a shadow copy and emits symmetric {plugged, letter} writes.
module plugboard_programmer #(
    parameter int ALPHABET_LEN = 26,
    parameter int PORTLEN      = 5,
    parameter int MAX_PLUGS    = 13,
    localparam int CW          = $clog2(MAX_PLUGS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [PORTLEN-1:0] cmd_a,
    input  logic [PORTLEN-1:0] cmd_b,
    output logic               wr_en,
    output logic [PORTLEN-1:0] wr_addr,
    output logic [PORTLEN:0]   wr_data,
    output logic               rsp_valid,
    output logic [2:0]         rsp_status,
    output logic [CW-1:0]      plug_count,
    output logic               busy
);

`ifndef SYNTH
    if (PORTLEN != $clog2(ALPHABET_LEN)) begin : g_portlen_check
        $error("PORTLEN must equal clog2(ALPHABET_LEN)");
    end
    if (MAX_PLUGS > ALPHABET_LEN / 2) begin : g_max_plugs_check
        $error("MAX_PLUGS must not exceed ALPHABET_LEN/2");
    end
`endif

    localparam logic [1:0] OP_PLUG   = 2'b00;
    localparam logic [1:0] OP_UNPLUG = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_RANGE    = 3'd1;
    localparam logic [2:0] ST_SELF     = 3'd2;
    localparam logic [2:0] ST_FULL     = 3'd3;
    localparam logic [2:0] ST_CONFLICT = 3'd4;
    localparam logic [2:0] ST_OP       = 3'd5;

    localparam logic [PORTLEN-1:0] LAST = PORTLEN'(ALPHABET_LEN - 1);
    localparam logic [CW-1:0]      FULL = CW'(MAX_PLUGS);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_CHECK, S_WR_A, S_WR_B, S_SWEEP, S_RESP
    } state_t;

    state_t             state, state_n;
    logic               run;
    logic [PORTLEN-1:0] idx, idx_n;
    logic [1:0]         op_r, op_n;
    logic [PORTLEN-1:0] a_r, a_n, b_r, b_n;
    logic [2:0]         status_r, status_n;
    logic [CW-1:0]      count_n;
    logic [PORTLEN:0]   shadow [ALPHABET_LEN];
    logic [PORTLEN:0]   sh_a, sh_b;

    function automatic logic [2:0] eval_cmd(
        input logic [1:0]         op,
        input logic [PORTLEN-1:0] a,
        input logic [PORTLEN-1:0] b,
        input logic               full,
        input logic [PORTLEN:0]   ent_a,
        input logic [PORTLEN:0]   ent_b
    );
        logic pair_op;
        pair_op = (op == OP_PLUG) || (op == OP_UNPLUG);
        if (op == OP_RSVD)                                  return ST_OP;
        if ((a > LAST) || (pair_op && (b > LAST)))          return ST_RANGE;
        if (pair_op && (a == b))                            return ST_SELF;
        if ((op == OP_PLUG) && full)                        return ST_FULL;
        if ((op == OP_PLUG) && (ent_a[PORTLEN] || ent_b[PORTLEN])) return ST_CONFLICT;
        if ((op == OP_UNPLUG) && (ent_a != {1'b1, b}))      return ST_CONFLICT;
        return ST_OK;
    endfunction

    // Out-of-range letters never reach a write; guard the reads so CHECK stays defined.
    assign sh_a = (a_r <= LAST) ? shadow[a_r] : '0;
    assign sh_b = (b_r <= LAST) ? shadow[b_r] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) shadow[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INIT;
            run        <= 1'b0;
            idx        <= '0;
            op_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            status_r   <= ST_OK;
            plug_count <= '0;
        end else begin
            state      <= state_n;
            run        <= 1'b1;
            idx        <= idx_n;
            op_r       <= op_n;
            a_r        <= a_n;
            b_r        <= b_n;
            status_r   <= status_n;
            plug_count <= count_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        op_n       = op_r;
        a_n        = a_r;
        b_n        = b_r;
        status_n   = status_r;
        count_n    = plug_count;
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rsp_valid  = 1'b0;
        rsp_status = '0;
        case (state)
            // run holds INIT silent while reset is asserted
            S_INIT: begin
                if (run) begin
                    busy    = 1'b1;
                    wr_en   = 1'b1;
                    wr_addr = idx;
                    if (idx == LAST) begin
                        idx_n   = '0;
                        state_n = S_IDLE;
                    end else begin
                        idx_n = idx + PORTLEN'(1);
                    end
                end
            end
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_n    = cmd_op;
                    a_n     = cmd_a;
                    b_n     = cmd_b;
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                busy     = 1'b1;
                status_n = eval_cmd(op_r, a_r, b_r, plug_count == FULL, sh_a, sh_b);
                if (status_n != ST_OK) begin
                    state_n = S_RESP;
                end else if (op_r == OP_CLEAR) begin
                    idx_n   = '0;
                    state_n = S_SWEEP;
                end else begin
                    state_n = S_WR_A;
                end
            end
            S_WR_A: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = a_r;
                wr_data = (op_r == OP_PLUG) ? {1'b1, b_r} : '0;
                state_n = S_WR_B;
            end
            S_WR_B: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = b_r;
                wr_data = (op_r == OP_PLUG) ? {1'b1, a_r} : '0;
                count_n = (op_r == OP_PLUG) ? plug_count + CW'(1) : plug_count - CW'(1);
                state_n = S_RESP;
            end
            S_SWEEP: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = idx;
                if (idx == LAST) begin
                    idx_n    = '0;
                    count_n  = '0;
                    status_n = ST_OK;
                    state_n  = S_RESP;
                end else begin
                    idx_n = idx + PORTLEN'(1);
                end
            end
            S_RESP: begin
                busy       = 1'b1;
                rsp_valid  = 1'b1;
                rsp_status = status_r;
                state_n    = S_IDLE;
            end
            default: state_n = S_INIT;
        endcase
    end

endmodule
